frame_mapper: RTL

Sender-side frame builder that sits directly upstream of the corruptor in the map path. Accepts a byte stream over a valid/ready handshake, emits 4-row × 1041-column frames as a byte stream with row/column position, a 16-byte frame alignment signal (FAS) header and a trailing CRC-8 byte. Its outputs drive the corruptor's data, valid, FAS, row and column inputs one-to-one.

---
 rtl/frame_pkg.sv | 58 +++++
 rtl/frame_crc8.sv | 39 +++
 rtl/frame_mapper.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/frame_pkg.sv
// -----------------------------------------------------------------------------
// frame_pkg
// Shared framing definitions for the map path: the frame geometry, the
// FAS/CRC positions, the framer state encoding and the CRC-8 byte step.
// The mapper, the corruptor and the receive-side deframer all import this,
// so the frame geometry is defined in exactly one place.
// -----------------------------------------------------------------------------
package frame_pkg;

    // Frame geometry
    localparam int unsigned FRAME_ROWS = 32'd4;
    localparam int unsigned FRAME_COLS = 32'd1041;
    localparam int unsigned FAS_LEN    = 32'd16;
    localparam int unsigned CRC_ROW    = 32'd3;
    localparam int unsigned CRC_COL    = 32'd1040;

    // CRC-8 generator x^8 + x^2 + x + 1, the x^8 term is implicit
    localparam logic [7:0] CRC_POLY = 8'h07;

    // Position counter types sized for the frame geometry
    typedef logic [1:0]  row_t;
    typedef logic [10:0] col_t;

    // Derived positions used by the framer
    localparam row_t LAST_ROW       = row_t'(FRAME_ROWS - 32'd1);
    localparam col_t LAST_COL       = col_t'(FRAME_COLS - 32'd1);
    localparam col_t FAS_LAST_COL   = col_t'(FAS_LEN - 32'd1);
    localparam col_t FAS_A_LAST_COL = col_t'((FAS_LEN / 32'd2) - 32'd1);
    localparam row_t CRC_ROW_IDX    = row_t'(CRC_ROW);
    localparam col_t CRC_COL_IDX    = col_t'(CRC_COL);
    // The last payload byte sits immediately before the CRC byte
    localparam col_t LAST_PYLD_COL  = col_t'(CRC_COL - 32'd1);

    // Framer state machine
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FAS     = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_CRC     = 2'd3
    } frame_state_e;

    // One byte of CRC-8: MSB-first, no reflection. The byte is folded into
    // the register first, then eight shift/conditional-xor steps follow.
    function automatic logic [7:0] crc8_byte(input logic [7:0] crc,
                                             input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 32'sd0; i < 32'sd8; i++) begin
            if (c[7]) begin
                c = {c[6:0], 1'b0} ^ CRC_POLY;
            end else begin
                c = {c[6:0], 1'b0};
            end
        end
        return c;
    endfunction

endpackage : frame_pkg

// File: rtl/frame_crc8.sv
// -----------------------------------------------------------------------------
// frame_crc8
// Registered CRC-8 accumulator for the frame payload.
//   clk    : clock
//   rst_n  : asynchronous active-low reset, clears the accumulator
//   clear  : synchronous clear to 0x00 (takes priority over update)
//   update : fold data into the accumulator this cycle
//   data   : byte to fold in
//   crc    : current accumulator value
// -----------------------------------------------------------------------------
module frame_crc8
    import frame_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       update,
    input  logic [7:0] data,
    output logic [7:0] crc
);

    logic [7:0] crc_r;

    // Accumulator register: clear wins, otherwise fold in the strobed byte
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_r <= 8'h00;
        end else if (clear) begin
            crc_r <= 8'h00;
        end else if (update) begin
            crc_r <= crc8_byte(crc_r, data);
        end else begin
            crc_r <= crc_r;
        end
    end

    assign crc = crc_r;

endmodule : frame_crc8

// File: rtl/frame_mapper.sv
// -----------------------------------------------------------------------------
// frame_mapper
// Sender-side frame builder. Wraps a client byte stream into 4 x 1041 byte
// frames: 16 FAS bytes at the start of row 0, payload everywhere else, and a
// CRC-8 of the payload in the last column of row 3. Output fields drive the
// corruptor inputs one-to-one.
//
// Parameters:
//   FAS_BYTE_A        : FAS byte for row 0 cols 0-7
//   FAS_BYTE_B        : FAS byte for row 0 cols 8-15
// Ports:
//   i_clk             : clock
//   i_rst_n           : asynchronous active-low reset
//   i_frame_en        : start/continue framing, looked at only between frames
//   i_data            : client payload byte
//   i_data_valid      : i_data is valid
//   o_data_ready      : payload byte accepted this cycle when valid (state only)
//   o_row_cnt         : row of the byte on o_pyld_data
//   o_col_cnt         : column of the byte on o_pyld_data
//   o_pyld_data       : framed byte
//   o_pyld_data_valid : o_pyld_data is valid
//   o_frame_data_fas  : high on the 16 FAS bytes
//   o_frame_done      : one-cycle pulse alongside the CRC byte
// -----------------------------------------------------------------------------
module frame_mapper
    import frame_pkg::*;
#(
    parameter logic [7:0] FAS_BYTE_A = 8'hF6,
    parameter logic [7:0] FAS_BYTE_B = 8'h28
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_frame_en,
    input  logic [7:0]  i_data,
    input  logic        i_data_valid,
    output logic        o_data_ready,
    output logic [1:0]  o_row_cnt,
    output logic [10:0] o_col_cnt,
    output logic [7:0]  o_pyld_data,
    output logic        o_pyld_data_valid,
    output logic        o_frame_data_fas,
    output logic        o_frame_done
);

    frame_state_e state_r;

    // Position of the next byte to be emitted
    row_t row_r;
    col_t col_r;

    // Registered output fields
    row_t       row_out_r;
    col_t       col_out_r;
    logic [7:0] data_out_r;
    logic       valid_out_r;
    logic       fas_out_r;
    logic       done_out_r;

    logic       data_ready_s;
    logic       crc_update_s;
    logic       crc_clear_s;
    logic [7:0] crc_value_s;

    // Handshake and CRC strobes are decoded from the state register alone,
    // so ready never depends on the upstream valid.
    always_comb begin
        data_ready_s = 1'b0;
        crc_update_s = 1'b0;
        crc_clear_s  = 1'b0;
        if (state_r == ST_PAYLOAD) begin
            data_ready_s = 1'b1;
            crc_update_s = i_data_valid;
        end else begin
            data_ready_s = 1'b0;
            crc_update_s = 1'b0;
        end
        if (state_r == ST_CRC) begin
            crc_clear_s = 1'b1;
        end else begin
            crc_clear_s = 1'b0;
        end
    end

    frame_crc8 u_crc8 (
        .clk    (i_clk),
        .rst_n  (i_rst_n),
        .clear  (crc_clear_s),
        .update (crc_update_s),
        .data   (i_data),
        .crc    (crc_value_s)
    );

    // Framer FSM: state, position counters and all registered outputs.
    // On cycles with no emitted byte, data/row/col hold and fas/done drop.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r     <= ST_IDLE;
            row_r       <= 2'd0;
            col_r       <= 11'd0;
            row_out_r   <= 2'd0;
            col_out_r   <= 11'd0;
            data_out_r  <= 8'h00;
            valid_out_r <= 1'b0;
            fas_out_r   <= 1'b0;
            done_out_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    valid_out_r <= 1'b0;
                    fas_out_r   <= 1'b0;
                    done_out_r  <= 1'b0;
                    row_r       <= 2'd0;
                    col_r       <= 11'd0;
                    if (i_frame_en) begin
                        state_r <= ST_FAS;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end

                ST_FAS: begin
                    // FAS bytes go out every cycle regardless of upstream
                    valid_out_r <= 1'b1;
                    fas_out_r   <= 1'b1;
                    done_out_r  <= 1'b0;
                    row_out_r   <= row_r;
                    col_out_r   <= col_r;
                    if (col_r <= FAS_A_LAST_COL) begin
                        data_out_r <= FAS_BYTE_A;
                    end else begin
                        data_out_r <= FAS_BYTE_B;
                    end
                    col_r <= col_r + 11'd1;
                    if (col_r == FAS_LAST_COL) begin
                        state_r <= ST_PAYLOAD;
                    end else begin
                        state_r <= ST_FAS;
                    end
                end

                ST_PAYLOAD: begin
                    fas_out_r  <= 1'b0;
                    done_out_r <= 1'b0;
                    if (i_data_valid) begin
                        valid_out_r <= 1'b1;
                        data_out_r  <= i_data;
                        row_out_r   <= row_r;
                        col_out_r   <= col_r;
                        if (col_r == LAST_COL) begin
                            col_r <= 11'd0;
                            if (row_r == LAST_ROW) begin
                                row_r <= 2'd0;
                            end else begin
                                row_r <= row_r + 2'd1;
                            end
                        end else begin
                            col_r <= col_r + 11'd1;
                        end
                        // Last payload byte just before the CRC slot
                        if ((row_r == CRC_ROW_IDX) && (col_r == LAST_PYLD_COL)) begin
                            state_r <= ST_CRC;
                        end else begin
                            state_r <= ST_PAYLOAD;
                        end
                    end else begin
                        // Stall: nothing emitted, position held
                        valid_out_r <= 1'b0;
                        state_r     <= ST_PAYLOAD;
                    end
                end

                ST_CRC: begin
                    // crc_value_s already includes the final payload byte
                    valid_out_r <= 1'b1;
                    fas_out_r   <= 1'b0;
                    done_out_r  <= 1'b1;
                    data_out_r  <= crc_value_s;
                    row_out_r   <= CRC_ROW_IDX;
                    col_out_r   <= CRC_COL_IDX;
                    row_r       <= 2'd0;
                    col_r       <= 11'd0;
                    if (i_frame_en) begin
                        state_r <= ST_FAS;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end

                default: begin
                    state_r     <= ST_IDLE;
                    row_r       <= 2'd0;
                    col_r       <= 11'd0;
                    valid_out_r <= 1'b0;
                    fas_out_r   <= 1'b0;
                    done_out_r  <= 1'b0;
                end
            endcase
        end
    end

    assign o_data_ready      = data_ready_s;
    assign o_row_cnt         = row_out_r;
    assign o_col_cnt         = col_out_r;
    assign o_pyld_data       = data_out_r;
    assign o_pyld_data_valid = valid_out_r;
    assign o_frame_data_fas  = fas_out_r;
    assign o_frame_done      = done_out_r;

endmodule : frame_mapper
